// File: rtl/glitc_corr_trigger.sv
// Thresholds two RITC correlator streams into an OR/AND coincidence trigger with holdoff, plus gated scalers/peaks.
// Latency: trig_o three clk after the corr sample; scalers latch on the gate terminal cycle.
// Backpressure: none, a new corr value is consumed every clk.
module glitc_corr_trigger #(
  parameter int CORR_BITS   = 12,
  parameter int SCALER_BITS = 16,
  parameter int GATE_BITS   = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   and_mode_i,
  input  logic [CORR_BITS-1:0]   corr0_i,
  input  logic [CORR_BITS-1:0]   corr1_i,
  input  logic [CORR_BITS-1:0]   thresh0_i,
  input  logic [CORR_BITS-1:0]   thresh1_i,
  input  logic [1:0]             mask_i,
  input  logic [3:0]             window_i,
  input  logic [7:0]             holdoff_i,
  input  logic [GATE_BITS-1:0]   gate_len_i,
  output logic                   trig_o,
  output logic [1:0]             trig_src_o,
  output logic [SCALER_BITS-1:0] scaler0_o,
  output logic [SCALER_BITS-1:0] scaler1_o,
  output logic [SCALER_BITS-1:0] trig_scaler_o,
  output logic [CORR_BITS-1:0]   peak0_o,
  output logic [CORR_BITS-1:0]   peak1_o,
  output logic                   scaler_valid_o
);

  typedef enum logic [1:0] {IDLE, TRIG, HOLD} state_t;

  localparam logic [GATE_BITS-1:0] GATE_ONE = {{(GATE_BITS-1){1'b0}}, 1'b1};

  logic [CORR_BITS-1:0]   corr0_q, corr1_q;
  logic                   hit0, hit1;
  logic [3:0]             cnt0, cnt1;
  logic                   str0, str1, cond;
  state_t                 state, state_nxt;
  logic [7:0]             hold_cnt;
  logic [GATE_BITS-1:0]   gate_cnt;
  logic [SCALER_BITS-1:0] run0, run1, run_trig;
  logic [SCALER_BITS-1:0] run0_nxt, run1_nxt, run_trig_nxt;
  logic [CORR_BITS-1:0]   pk0, pk1, pk0_nxt, pk1_nxt;

  function automatic logic [SCALER_BITS-1:0] sat_inc(input logic [SCALER_BITS-1:0] v,
                                                     input logic inc);
    return (inc && (v != {SCALER_BITS{1'b1}})) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      corr0_q <= '0;
      corr1_q <= '0;
      hit0    <= 1'b0;
      hit1    <= 1'b0;
      cnt0    <= '0;
      cnt1    <= '0;
    end else begin
      corr0_q <= corr0_i;
      corr1_q <= corr1_i;
      hit0    <= (corr0_q >= thresh0_i) & ~mask_i[0];
      hit1    <= (corr1_q >= thresh1_i) & ~mask_i[1];
      if (hit0)              cnt0 <= window_i;
      else if (cnt0 != 4'd0) cnt0 <= cnt0 - 1'b1;
      if (hit1)              cnt1 <= window_i;
      else if (cnt1 != 4'd0) cnt1 <= cnt1 - 1'b1;
    end
  end

  assign str0 = hit0 | (cnt0 != 4'd0);
  assign str1 = hit1 | (cnt1 != 4'd0);
  assign cond = enable_i & (and_mode_i ? (str0 & str1) : (str0 | str1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cond) state_nxt = TRIG;
      TRIG:    state_nxt = (hold_cnt != 8'd0) ? HOLD : IDLE;
      HOLD:    if (hold_cnt == 8'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable_i) state_nxt = IDLE;
  end

  // trig_o is registered from the next state so it equals (state == TRIG)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      trig_o     <= 1'b0;
      trig_src_o <= '0;
    end else begin
      state  <= state_nxt;
      trig_o <= (state_nxt == TRIG);
      if (state_nxt == TRIG) begin
        trig_src_o <= {str1, str0};
        hold_cnt   <= holdoff_i;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    run0_nxt     = sat_inc(run0, hit0);
    run1_nxt     = sat_inc(run1, hit1);
    run_trig_nxt = sat_inc(run_trig, state == TRIG);
    pk0_nxt      = (corr0_q > pk0) ? corr0_q : pk0;
    pk1_nxt      = (corr1_q > pk1) ? corr1_q : pk1;
  end

  // gate_cnt == 0 means "reload pending": sample gate_len_i, keep running values cleared
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate_cnt       <= '0;
      run0           <= '0;
      run1           <= '0;
      run_trig       <= '0;
      pk0            <= '0;
      pk1            <= '0;
      scaler0_o      <= '0;
      scaler1_o      <= '0;
      trig_scaler_o  <= '0;
      peak0_o        <= '0;
      peak1_o        <= '0;
      scaler_valid_o <= 1'b0;
    end else begin
      scaler_valid_o <= 1'b0;
      if (gate_cnt == '0 || gate_cnt == GATE_ONE) begin
        if (gate_cnt == GATE_ONE) begin
          scaler0_o      <= run0_nxt;
          scaler1_o      <= run1_nxt;
          trig_scaler_o  <= run_trig_nxt;
          peak0_o        <= pk0_nxt;
          peak1_o        <= pk1_nxt;
          scaler_valid_o <= 1'b1;
        end
        gate_cnt <= gate_len_i;
        run0     <= '0;
        run1     <= '0;
        run_trig <= '0;
        pk0      <= '0;
        pk1      <= '0;
      end else begin
        gate_cnt <= gate_cnt - 1'b1;
        run0     <= run0_nxt;
        run1     <= run1_nxt;
        run_trig <= run_trig_nxt;
        pk0      <= pk0_nxt;
        pk1      <= pk1_nxt;
      end
    end
  end

endmodule

// File: tb/tb_glitc_corr_trigger.sv
// Directed bench for glitc_corr_trigger: trigger vector table plus holdoff, gate, saturation and reset sequences.
module tb_glitc_corr_trigger;

  logic        clk = 1'b0;
  logic        rst, enable, and_mode;
  logic [11:0] corr0, corr1, thresh0, thresh1;
  logic [1:0]  mask;
  logic [3:0]  window;
  logic [7:0]  holdoff;
  logic [23:0] gate_len, gate_len_s;

  logic        trig, vld;
  logic [1:0]  src;
  logic [15:0] sc0, sc1, sct;
  logic [11:0] pk0, pk1;

  logic        s_trig, s_vld;
  logic [1:0]  s_src;
  logic [3:0]  s_sc0, s_sc1, s_sct;
  logic [11:0] s_pk0, s_pk1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  glitc_corr_trigger u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .and_mode_i(and_mode),
    .corr0_i(corr0), .corr1_i(corr1), .thresh0_i(thresh0), .thresh1_i(thresh1),
    .mask_i(mask), .window_i(window), .holdoff_i(holdoff), .gate_len_i(gate_len),
    .trig_o(trig), .trig_src_o(src), .scaler0_o(sc0), .scaler1_o(sc1),
    .trig_scaler_o(sct), .peak0_o(pk0), .peak1_o(pk1), .scaler_valid_o(vld)
  );

  glitc_corr_trigger #(.SCALER_BITS(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .and_mode_i(and_mode),
    .corr0_i(corr0), .corr1_i(corr1), .thresh0_i(thresh0), .thresh1_i(thresh1),
    .mask_i(mask), .window_i(window), .holdoff_i(holdoff), .gate_len_i(gate_len_s),
    .trig_o(s_trig), .trig_src_o(s_src), .scaler0_o(s_sc0), .scaler1_o(s_sc1),
    .trig_scaler_o(s_sct), .peak0_o(s_pk0), .peak1_o(s_pk1), .scaler_valid_o(s_vld)
  );

  typedef struct {
    logic        en;
    logic        andm;
    logic [1:0]  msk;
    logic [3:0]  win;
    logic [11:0] c0;
    logic [11:0] c1;
    int          d1;
    int          exp_n;
    int          exp_first;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t vecs[13];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  initial begin
    int n_trig, first, gap_bad, last, nv, t1, t2, s_seen, main_v;
    logic [1:0] first_src;

    // thresholds 100/100, holdoff 0 throughout the table
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 4'd0, 12'd100, 12'd0,   0, 1, 3, 2'b01};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 4'd0, 12'd99,  12'd0,   0, 0, 0, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 4'd0, 12'd0,   12'd200, 0, 1, 3, 2'b10};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 4'd0, 12'd100, 12'd100, 2, 2, 3, 2'b01};
    vecs[4]  = '{1'b1, 1'b1, 2'b00, 4'd2, 12'd100, 12'd100, 2, 1, 5, 2'b11};
    vecs[5]  = '{1'b1, 1'b1, 2'b00, 4'd2, 12'd100, 12'd100, 3, 0, 0, 2'b00};
    vecs[6]  = '{1'b1, 1'b1, 2'b10, 4'd2, 12'd100, 12'd100, 2, 0, 0, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 2'b11, 4'd0, 12'd500, 12'd500, 0, 0, 0, 2'b00};
    vecs[8]  = '{1'b1, 1'b1, 2'b00, 4'd0, 12'd100, 12'd100, 0, 1, 3, 2'b11};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 4'd3, 12'd100, 12'd0,   0, 2, 3, 2'b01};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 4'd0, 12'd100, 12'd0,   0, 0, 0, 2'b00};
    vecs[11] = '{1'b1, 1'b0, 2'b01, 4'd0, 12'd100, 12'd0,   0, 0, 0, 2'b00};
    vecs[12] = '{1'b1, 1'b0, 2'b01, 4'd0, 12'd300, 12'd300, 0, 1, 3, 2'b10};

    rst = 1'b1; enable = 1'b1; and_mode = 1'b0;
    corr0 = '0; corr1 = '0; thresh0 = 12'd100; thresh1 = 12'd100;
    mask = '0; window = '0; holdoff = '0; gate_len = 24'd1000; gate_len_s = 24'd100;
    tick; tick;
    check("reset_trig", {31'd0, trig}, 0);
    check("reset_src", {30'd0, src}, 0);
    check("reset_scaler0", {16'd0, sc0}, 0);
    check("reset_trig_scaler", {16'd0, sct}, 0);
    check("reset_peak0", {20'd0, pk0}, 0);
    check("reset_valid", {31'd0, vld}, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      enable = vecs[i].en; and_mode = vecs[i].andm; mask = vecs[i].msk; window = vecs[i].win;
      corr0 = '0; corr1 = '0;
      repeat (8) tick;
      n_trig = 0; first = -1; first_src = '0;
      for (int c = 0; c < 16; c++) begin
        corr0 = (c == 0) ? vecs[i].c0 : 12'd0;
        corr1 = (c == vecs[i].d1) ? vecs[i].c1 : 12'd0;
        tick;
        if (trig) begin
          n_trig++;
          if (first < 0) begin first = c + 1; first_src = src; end
        end
      end
      check($sformatf("vec%0d_ntrig", i), n_trig, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        check($sformatf("vec%0d_first", i), first, vecs[i].exp_first);
        check($sformatf("vec%0d_src", i), {30'd0, first_src}, {30'd0, vecs[i].exp_src});
      end
    end

    // sustained hit with holdoff 3: pulses every 5 cycles
    enable = 1'b1; and_mode = 1'b0; mask = '0; window = '0; holdoff = 8'd3;
    corr0 = '0; corr1 = '0;
    repeat (8) tick;
    n_trig = 0; first = -1; last = -1; gap_bad = 0;
    for (int c = 0; c < 30; c++) begin
      corr0 = (c < 20) ? 12'd100 : 12'd0;
      tick;
      if (trig) begin
        n_trig++;
        if (first < 0) first = c + 1;
        if (last >= 0 && (c + 1 - last) != 5) gap_bad++;
        last = c + 1;
      end
    end
    check("holdoff_ntrig", n_trig, 4);
    check("holdoff_first", first, 3);
    check("holdoff_bad_gaps", gap_bad, 0);
    repeat (8) tick;
    n_trig = 0;
    for (int c = 0; c < 30; c++) begin
      corr0 = (c < 20) ? 12'd99 : 12'd0;
      tick;
      if (trig) n_trig++;
    end
    check("below_thresh_ntrig", n_trig, 0);

    // gate of 1000: gate 1 has 10 hits (one at 0x7FF), gate 2 has 3 hits of 300
    holdoff = 8'd0; corr0 = '0; corr1 = '0;
    rst = 1'b1; tick; rst = 1'b0;
    nv = 0; t1 = -1; t2 = -1;
    for (int c = 0; c < 2100 && nv < 2; c++) begin
      if (c >= 100 && c <= 190 && (c % 10) == 0) corr0 = (c == 150) ? 12'h7FF : 12'd200;
      else if (c == 1100 || c == 1200 || c == 1300) corr0 = 12'd300;
      else corr0 = 12'd0;
      corr1 = (c == 300) ? 12'd50 : 12'd0;
      tick;
      if (vld) begin
        nv++;
        if (nv == 1) begin
          t1 = c + 1;
          check("gate1_time_ok", {31'd0, (t1 >= 999 && t1 <= 1002)}, 1);
          check("gate1_scaler0", {16'd0, sc0}, 10);
          check("gate1_peak0", {20'd0, pk0}, 32'h7FF);
          check("gate1_trig_scaler", {16'd0, sct}, 10);
          check("gate1_scaler1", {16'd0, sc1}, 0);
          check("gate1_peak1", {20'd0, pk1}, 50);
        end else begin
          t2 = c + 1;
          check("gate_period", t2 - t1, 1000);
          check("gate2_scaler0", {16'd0, sc0}, 3);
          check("gate2_peak0", {20'd0, pk0}, 300);
          check("gate2_trig_scaler", {16'd0, sct}, 3);
          check("gate2_peak1", {20'd0, pk1}, 0);
        end
      end
    end
    check("gate_valid_count", nv, 2);

    // reset during HOLD and mid-gate
    holdoff = 8'd100;
    corr0 = 12'd200; tick; corr0 = '0; tick; tick;
    check("pre_reset_trig", {31'd0, trig}, 1);
    repeat (5) tick;
    rst = 1'b1; tick;
    check("rst_trig", {31'd0, trig}, 0);
    check("rst_src", {30'd0, src}, 0);
    check("rst_scaler0", {16'd0, sc0}, 0);
    check("rst_scaler1", {16'd0, sc1}, 0);
    check("rst_trig_scaler", {16'd0, sct}, 0);
    check("rst_peak0", {20'd0, pk0}, 0);
    check("rst_peak1", {20'd0, pk1}, 0);
    check("rst_valid", {31'd0, vld}, 0);
    holdoff = 8'd0; gate_len = 24'd0;
    rst = 1'b0;
    corr0 = 12'd200; tick; corr0 = '0; tick; tick;
    check("post_reset_trig", {31'd0, trig}, 1);

    // 4-bit scalers saturate; main DUT has gate_len 0 and must stay silent
    s_seen = 0; main_v = 0;
    for (int c = 0; c < 300; c++) begin
      corr0 = (c >= 10 && c < 70 && ((c - 10) % 3) == 0) ? 12'd200 : 12'd0;
      tick;
      if (vld) main_v++;
      if (s_vld && s_seen == 0) begin
        s_seen = 1;
        check("sat_scaler0", {28'd0, s_sc0}, 15);
        check("sat_trig_scaler", {28'd0, s_sct}, 15);
      end
    end
    check("sat_valid_seen", s_seen, 1);
    check("gate_len0_no_valid", main_v, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
